// File: rtl/output_sync_arbiter_pkg.sv
// Shared constants and helpers for the output synchronising arbiter.
//   TAG_LSB_DEF / TAG_W_DEF / READY_TAG_DEF : default tag field position and
//                                             the tag value that marks a ready request
//   idx_w(n)                                : width of a channel index for n channels
package output_sync_arbiter_pkg;

  localparam int         TAG_LSB_DEF   = 8;
  localparam int         TAG_W_DEF     = 4;
  localparam logic [3:0] READY_TAG_DEF = 4'h2;

  // Never returns 0 so that index ports stay legal for any channel count.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/out_sync_prio_sel.sv
// Combinational grant selector for the output synchronising arbiter.
// Optional feature macro: OUT_SYNC_RR_EN
//   undefined : fixed priority, the highest requesting index wins (ptr ignored)
//   defined   : round-robin, the first requester found at or after ptr,
//               wrapping modulo N, wins
// Ports:
//   req       : one bit per channel, channel has a word waiting
//   ptr       : round-robin start index
//   grant_idx : index of the winning channel (0 when grant_any=0)
//   grant_any : at least one channel is requesting
module out_sync_prio_sel
  import output_sync_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

`ifdef OUT_SYNC_RR_EN
  // Pick the requester with the smallest forward distance from ptr.
  always_comb begin
    int best_dist;
    int dist;
    best_dist = N;
    dist      = 0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int c = 0; c < N; c++) begin
      dist = (c - int'(ptr) + N) % N;
      if (req[c] && (dist < best_dist)) begin
        best_dist = dist;
        grant_idx = IDX_W'(c);
        grant_any = 1'b1;
      end
    end
  end
`else
  // The pointer has no meaning for fixed priority.
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Ascending scan: the last hit, i.e. the highest index, wins.
  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (req[c]) begin
        grant_idx = IDX_W'(c);
        grant_any = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/output_sync_arbiter.sv
// Output synchronising arbiter: watches NUM_PERIPH peripheral words for a
// ready tag, captures each rising-edge request into a one-entry per-channel
// slot, and arbitrates the slots onto a single registered output. When no
// peripheral word is waiting, the scheduler's next_task is forwarded instead.
// Optional feature macro: OUT_SYNC_RR_EN (round-robin arbitration with a
// pointer register; default build is fixed highest-index priority).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   next_task    : scheduler word, forwarded (zero-extended) when idle
//   periph_data  : channel i at [i*WORD_W +: WORD_W]
//   out          : registered output word
//   out_valid    : out holds a peripheral word
//   out_src      : channel that supplied out (0 when out_valid=0)
//   out_ready    : consumer accept
//   ovf, ovf_clr : sticky per-channel overflow flags and their clear
// Handshake: a peripheral word transfers on a cycle where out_valid && out_ready.
// While out_valid=1 and out_ready=0, out and out_src hold. When out_valid=0
// the output register reloads every cycle.
module output_sync_arbiter
  import output_sync_arbiter_pkg::*;
#(
  parameter int               NUM_PERIPH = 2,
  parameter int               WORD_W     = 16,
  parameter int               TASK_W     = 8,
  parameter int               TAG_LSB    = TAG_LSB_DEF,
  parameter int               TAG_W      = TAG_W_DEF,
  parameter logic [TAG_W-1:0] READY_TAG  = TAG_W'(READY_TAG_DEF)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [TASK_W-1:0]            next_task,
  input  logic [NUM_PERIPH*WORD_W-1:0] periph_data,
  output logic [WORD_W-1:0]            out,
  output logic                         out_valid,
  output logic [idx_w(NUM_PERIPH)-1:0] out_src,
  input  logic                         out_ready,
  output logic [NUM_PERIPH-1:0]        ovf,
  input  logic                         ovf_clr
);

  localparam int IDX_W = idx_w(NUM_PERIPH);

  logic [NUM_PERIPH-1:0]             match;
  logic [NUM_PERIPH-1:0]             match_q;
  logic [NUM_PERIPH-1:0]             req_evt;
  logic [NUM_PERIPH-1:0]             slot_full_q, slot_full_d;
  logic [NUM_PERIPH-1:0][WORD_W-1:0] slot_data_q, slot_data_d;
  logic [NUM_PERIPH-1:0]             ovf_q, ovf_d;
  logic [WORD_W-1:0]                 out_q, out_d;
  logic                              out_valid_q, out_valid_d;
  logic [IDX_W-1:0]                  out_src_q, out_src_d;

  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic                  load_en;
  logic                  do_grant;
  logic [NUM_PERIPH-1:0] grant_vec;

  // Tag compare; a request is the first cycle of a match only.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      match[i] = (periph_data[i*WORD_W + TAG_LSB +: TAG_W] == READY_TAG);
    end
  end

  assign req_evt = match & ~match_q;

  out_sync_prio_sel #(
    .N     (NUM_PERIPH),
    .IDX_W (IDX_W)
  ) u_prio_sel (
    .req       (slot_full_q),
    .ptr       (ptr),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // The output register can take a new word when empty or being accepted.
  assign load_en  = !out_valid_q || out_ready;
  assign do_grant = grant_any && load_en;

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      grant_vec[i] = do_grant && (grant_idx == IDX_W'(i));
    end
  end

  // Slots and overflow. A granted slot empties this cycle, so a request
  // arriving on the same cycle refills it instead of overflowing. The clear
  // is applied before new overflows so that a coincident set wins.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    ovf_d       = ovf_clr ? '0 : ovf_q;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (grant_vec[i]) begin
        slot_full_d[i] = 1'b0;
      end
      if (req_evt[i]) begin
        if (!slot_full_q[i] || grant_vec[i]) begin
          slot_full_d[i] = 1'b1;
          slot_data_d[i] = periph_data[i*WORD_W +: WORD_W];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    if (load_en) begin
      if (grant_any) begin
        out_d       = slot_data_q[grant_idx];
        out_valid_d = 1'b1;
        out_src_d   = grant_idx;
      end else begin
        out_d       = WORD_W'(next_task);
        out_valid_d = 1'b0;
        out_src_d   = '0;
      end
    end
  end

  // Match history resets to 0, so a match held through reset is seen as a
  // fresh request on the first clock afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q     <= '0;
      slot_full_q <= '0;
      slot_data_q <= '0;
      ovf_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
    end else begin
      match_q     <= match;
      slot_full_q <= slot_full_d;
      slot_data_q <= slot_data_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  end

`ifdef OUT_SYNC_RR_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Next search starts one past the channel just granted.
  always_comb begin
    ptr_d = ptr_q;
    if (do_grant) begin
      ptr_d = (grant_idx == IDX_W'(NUM_PERIPH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;
  assign ovf       = ovf_q;

endmodule
